vga_frame_reader: RTL and testbench

Read side of the filtered-image buffer in data memory. The filter GPU writes 8-bit grayscale pixels into dmem; this block fetches them back word by word over a shared read port. It uses the VGA controller's hcount/vcount to place each pixel and drives ir/ig/ib. It sits between the dmem read arbiter and the VGA controller's colour inputs.

---
 rtl/vga_frame_reader.sv | 144 ++++++++++++++
 tb/tb_vga_frame_reader.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/vga_frame_reader.sv
// Fetches 8-bit grayscale pixels from dmem one word at a time and places them on
// the VGA colour outputs using the controller's hcount/vcount.
module vga_frame_reader #(
    parameter int          IMG_W    = 256,
    parameter int          IMG_H    = 256,
    parameter logic [31:0] BASE_ADR = 32'h0000_0000,
    parameter int          X0       = 192,
    parameter int          Y0       = 112,
    parameter int          PREFETCH = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        pix_en,
    input  logic [9:0]  hcount,
    input  logic [9:0]  vcount,
    output logic        rd_en,
    output logic [31:0] rd_adr,
    input  logic        rd_gnt,
    input  logic [31:0] rd_data,
    output logic [7:0]  ir,
    output logic [7:0]  ig,
    output logic [7:0]  ib,
    output logic        underrun,
    output logic        frame_done
);

    localparam int WL_W = $clog2(IMG_W / 4 + 1);
    localparam logic [WL_W-1:0] WORDS_ROW = WL_W'(IMG_W / 4);
    localparam logic [9:0] X0_C   = 10'(X0);
    localparam logic [9:0] X_END  = 10'(X0 + IMG_W);
    localparam logic [9:0] Y0_C   = 10'(Y0);
    localparam logic [9:0] Y_END  = 10'(Y0 + IMG_H);
    localparam logic [9:0] ROW_H  = 10'(X0 - PREFETCH);
    localparam logic [9:0] X_LAST = 10'(IMG_W - 1);
    localparam logic [9:0] Y_LAST = 10'(IMG_H - 1);

    typedef enum logic [1:0] {IDLE, REQ, WAIT, HOLD} state_t;

    state_t            state, state_n;
    logic [31:0]       ptr;
    logic [WL_W-1:0]   words_left;
    logic [31:0]       fifo_mem [2];
    logic              wr_ptr, rd_ptr;
    logic [1:0]        cnt, cnt_n;
    logic              push, pop;
    logic [7:0]        pix_p1;

    logic        in_rows, in_region, row_start, fifo_empty;
    logic [9:0]  x, y;
    logic [31:0] row_base;

    function automatic logic [7:0] lane_sel(input logic [31:0] w, input logic [1:0] lane);
        case (lane)
            2'd0:    lane_sel = w[7:0];
            2'd1:    lane_sel = w[15:8];
            2'd2:    lane_sel = w[23:16];
            default: lane_sel = w[31:24];
        endcase
    endfunction

    assign x          = hcount - X0_C;
    assign y          = vcount - Y0_C;
    assign in_rows    = (vcount >= Y0_C) && (vcount < Y_END);
    assign in_region  = in_rows && (hcount >= X0_C) && (hcount < X_END);
    assign row_start  = pix_en && in_rows && (hcount == ROW_H);
    assign row_base   = BASE_ADR + ({22'd0, y} * 32'(IMG_W));
    assign fifo_empty = (cnt == 2'd0);

    // A row start flushes the FIFO, so a read landing in the same cycle is discarded.
    assign push = (state == WAIT) && !row_start;
    assign pop  = pix_en && in_region && !fifo_empty && (x[1:0] == 2'd3);

    always_comb begin
        cnt_n = cnt;
        if (row_start) cnt_n = 2'd0;
        else           cnt_n = cnt + {1'b0, push} - {1'b0, pop};
    end

    always_comb begin
        state_n = state;
        case (state)
            IDLE: state_n = IDLE;
            REQ:  if (rd_gnt) state_n = WAIT;
            WAIT: begin
                if (words_left == WL_W'(1)) state_n = IDLE;
                else if (cnt_n != 2'd2)     state_n = REQ;
                else                        state_n = HOLD;
            end
            HOLD: if (cnt_n != 2'd2) state_n = REQ;
            default: state_n = IDLE;
        endcase
        if (row_start) state_n = REQ;
    end

    assign rd_en = (state == REQ);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= IDLE;
            cnt        <= 2'd0;
            wr_ptr     <= 1'b0;
            rd_ptr     <= 1'b0;
            ptr        <= BASE_ADR;
            words_left <= '0;
            rd_adr     <= 32'd0;
            pix_p1     <= 8'd0;
            underrun   <= 1'b0;
            frame_done <= 1'b0;
        end else begin
            state <= state_n;
            cnt   <= cnt_n;
            if (row_start) begin
                wr_ptr     <= 1'b0;
                rd_ptr     <= 1'b0;
                ptr        <= row_base;
                rd_adr     <= row_base;
                words_left <= WORDS_ROW;
            end else begin
                if (push) begin
                    wr_ptr     <= ~wr_ptr;
                    ptr        <= ptr + 32'd4;
                    rd_adr     <= ptr + 32'd4;
                    words_left <= words_left - WL_W'(1);
                end
                if (pop) rd_ptr <= ~rd_ptr;
            end
            // pixel stage: output registered on the strobe that sampled hcount/vcount
            frame_done <= pix_en && in_region && (x == X_LAST) && (y == Y_LAST);
            if (pix_en) begin
                if (in_region && fifo_empty) underrun <= 1'b1;
                pix_p1 <= (in_region && !fifo_empty) ? lane_sel(fifo_mem[rd_ptr], x[1:0]) : 8'd0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push) fifo_mem[wr_ptr] <= rd_data;
    end

    assign ir = pix_p1;
    assign ig = pix_p1;
    assign ib = pix_p1;

endmodule

// File: tb/tb_vga_frame_reader.sv
// Scoreboard bench for vga_frame_reader: a dmem/arbiter model answers reads and
// every pixel strobe queues the expected colour, compared the clk after.
module tb_vga_frame_reader;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        pix_en;
    logic [9:0]  hcount, vcount;
    logic        rd_en;
    logic [31:0] rd_adr;
    logic        rd_gnt;
    logic [31:0] rd_data;
    logic [7:0]  ir, ig, ib;
    logic        underrun, frame_done;

    typedef struct packed {
        logic [7:0] pix;
        logic       fd;
    } exp_t;

    exp_t        sb[$];
    int          n_tests = 0;
    int          n_fail  = 0;
    int          grants = 0;
    int          rden_cycles = 0;
    int          fd_pulses = 0;
    int          pix_div = 1;
    logic [31:0] first_adr = 0, last_adr = 0;
    logic        pix_en_q = 1'b0;

    vga_frame_reader dut (
        .clk(clk), .reset(rst_n), .pix_en(pix_en), .hcount(hcount), .vcount(vcount),
        .rd_en(rd_en), .rd_adr(rd_adr), .rd_gnt(rd_gnt), .rd_data(rd_data),
        .ir(ir), .ig(ig), .ib(ib), .underrun(underrun), .frame_done(frame_done)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        logic [31:0] h;
        if (a == 32'd0) return 32'h4433_2211;
        h = a * 32'h9E37_79B1;
        return h ^ {h[14:0], h[31:15]};
    endfunction

    function automatic logic [7:0] pixbyte(input logic [31:0] o);
        logic [31:0] w;
        w = mem_word({o[31:2], 2'b00});
        return w[8*o[1:0] +: 8];
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // dmem + arbiter model: data returned the cycle after the grant
    always @(posedge clk) begin
        pix_en_q <= pix_en;
        if (rd_en) rden_cycles++;
        if (rd_en && rd_gnt) begin
            if (grants == 0) first_adr = rd_adr;
            last_adr = rd_adr;
            grants++;
            rd_data <= mem_word(rd_adr);
        end
    end

    always @(negedge clk) begin
        exp_t e;
        if (frame_done === 1'b1) fd_pulses++;
        if (pix_en_q) begin
            if (sb.size() == 0) check("sb_empty", 32'd1, 32'd0);
            else begin
                e = sb.pop_front();
                check("pix", {8'd0, ir, ig, ib}, {8'd0, e.pix, e.pix, e.pix});
                check("frame_done", {31'd0, frame_done}, {31'd0, e.fd});
            end
        end
    end

    task automatic step(input int h, input int v, input bit ok);
        exp_t e;
        int   x, y;
        bit   in_r;
        @(negedge clk);
        pix_en = 1'b1;
        hcount = 10'(h);
        vcount = 10'(v);
        in_r   = (h >= 192) && (h < 448) && (v >= 112) && (v < 368);
        x      = h - 192;
        y      = v - 112;
        e.pix  = (in_r && ok) ? pixbyte(32'(y * 256 + x)) : 8'd0;
        e.fd   = in_r && (x == 255) && (y == 255);
        sb.push_back(e);
        if (pix_div == 2) begin
            @(negedge clk);
            pix_en = 1'b0;
        end
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk);
            pix_en = 1'b0;
        end
    endtask

    task automatic row(input int v, input int h0, input int h1, input bit ok);
        for (int h = h0; h <= h1; h++) step(h, v, ok);
        idle(4);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0; pix_en = 1'b0; hcount = 10'd0; vcount = 10'd0;
        rd_gnt = 1'b0; rd_data = 32'd0;
        #12;
        check("rst_rd_en", {31'd0, rd_en}, 32'd0);
        check("rst_rd_adr", rd_adr, 32'd0);
        check("rst_pix", {8'd0, ir, ig, ib}, 32'd0);
        check("rst_underrun", {31'd0, underrun}, 32'd0);
        check("rst_frame_done", {31'd0, frame_done}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // row 0, continuous grant
        rd_gnt = 1'b1; grants = 0;
        row(112, 180, 455, 1'b1);
        check("row0_first_adr", first_adr, 32'h0);
        check("row0_grants", grants, 64);

        // y=5 address range and grant count
        grants = 0;
        row(117, 180, 455, 1'b1);
        check("y5_first_adr", first_adr, 32'h500);
        check("y5_last_adr", last_adr, 32'h5FC);
        check("y5_grants", grants, 64);
        check("y5_idle_rd_en", {31'd0, rd_en}, 32'd0);

        // row above the image: no fetch, black
        rden_cycles = 0;
        row(111, 180, 455, 1'b1);
        check("above_rd_en", rden_cycles, 0);
        check("no_underrun", {31'd0, underrun}, 32'd0);

        // reset while a request is pending without grant
        for (int h = 184; h <= 193; h++) step(h, 112, 1'b1);
        rd_gnt = 1'b0;
        step(194, 112, 1'b1);
        step(195, 112, 1'b1);
        @(negedge clk);
        pix_en = 1'b0;
        check("req_pending", {31'd0, rd_en}, 32'd1);
        #2 rst_n = 1'b0;
        #1;
        check("async_rd_en", {31'd0, rd_en}, 32'd0);
        check("async_rd_adr", rd_adr, 32'd0);
        check("async_pix", {8'd0, ir, ig, ib}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1; rd_gnt = 1'b1; rden_cycles = 0;
        for (int h = 196; h <= 260; h++) step(h, 112, 1'b0);
        idle(4);
        check("post_rst_no_rd", rden_cycles, 0);
        grants = 0;
        row(113, 180, 455, 1'b1);
        check("post_rst_first_adr", first_adr, 32'h100);
        check("post_rst_grants", grants, 64);
        check("post_rst_underrun", {31'd0, underrun}, 32'd1);

        // starved row, then recovery at the next row start
        do_reset();
        rd_gnt = 1'b0;
        row(120, 180, 455, 1'b0);
        check("starve_underrun", {31'd0, underrun}, 32'd1);
        check("starve_rd_en_held", {31'd0, rd_en}, 32'd1);
        check("starve_rd_adr_held", rd_adr, 32'h800);
        rd_gnt = 1'b1;
        row(121, 180, 455, 1'b1);
        check("recover_underrun_sticky", {31'd0, underrun}, 32'd1);

        // end of frame at half pixel rate
        do_reset();
        pix_div = 2; fd_pulses = 0;
        row(366, 180, 455, 1'b1);
        row(367, 180, 455, 1'b1);
        row(368, 180, 455, 1'b1);
        check("frame_done_pulses", fd_pulses, 1);
        check("frame_sb_drained", sb.size(), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
